// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between the fetch (I) and load/store (D) ports; one transaction
// outstanding at a time. Define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of D-over-I priority.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_flush,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam logic OwnD = 1'b0;
  localparam logic OwnI = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic grant_i, grant_d;
  logic i_hs, d_hs;
  logic rsp_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie, the port that did not win last time goes first.
  always_comb begin
    grant_i = i_req_valid;
    grant_d = d_req_valid;
    if (i_req_valid && d_req_valid) begin
      grant_i = (last_q == OwnD);
      grant_d = (last_q == OwnI);
    end
  end

  always_comb begin
    last_d = last_q;
    if (i_hs) last_d = OwnI;
    else if (d_hs) last_d = OwnD;
  end

  always_ff @(posedge clk) begin
    if (!rstn) last_q <= OwnD;
    else       last_q <= last_d;
  end
`else
  logic [3:0] starve_q, starve_d;
  logic       starve_hit;

  assign starve_hit = (32'(starve_q) >= STARVE_LIMIT);
  assign grant_i    = i_req_valid && (!d_req_valid || starve_hit);
  assign grant_d    = d_req_valid && !grant_i;

  // Counts D wins that left a fetch waiting; saturates rather than wrapping.
  always_comb begin
    starve_d = starve_q;
    if (i_hs) starve_d = 4'd0;
    else if (d_hs && i_req_valid && (starve_q != 4'hf)) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`endif

  assign i_hs = (state_q == StIdle) && grant_i;
  assign d_hs = (state_q == StIdle) && grant_d;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      StIdle: begin
        if (i_hs) begin
          owner_d = OwnI;
          addr_d  = i_req_addr;
          we_d    = 1'b0;
          wdata_d = 32'd0;
          wstrb_d = 4'd0;
          kill_d  = 1'b0;
          state_d = StIssue;
        end else if (d_hs) begin
          owner_d = OwnD;
          addr_d  = d_req_addr;
          we_d    = d_req_we;
          wdata_d = d_req_wdata;
          wstrb_d = d_req_we ? d_req_wstrb : 4'd0;
          kill_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: if (mem_req_ready) state_d = StWait;
      StWait:  if (mem_rsp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A redirect orphans the outstanding fetch; its response is still consumed later.
    if ((state_q == StIssue || state_q == StWait) && owner_q == OwnI && i_flush) kill_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= OwnD;
      kill_q  <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign rsp_fire = rstn && (state_q == StWait) && mem_rsp_valid;

  assign i_req_ready   = rstn && i_hs;
  assign d_req_ready   = rstn && d_hs;
  assign mem_req_valid = rstn && (state_q == StIssue);
  assign mem_req_addr  = rstn ? addr_q : 32'd0;
  assign mem_req_we    = rstn && we_q;
  assign mem_req_wdata = rstn ? wdata_q : 32'd0;
  assign mem_req_wstrb = rstn ? wstrb_q : 4'd0;

  // A flush coinciding with the response also suppresses it.
  assign i_rsp_valid = rsp_fire && (owner_q == OwnI) && !kill_q && !i_flush;
  assign d_rsp_valid = rsp_fire && (owner_q == OwnD);
  assign i_rsp_data  = rstn ? mem_rsp_data : 32'd0;
  assign d_rsp_data  = rstn ? mem_rsp_data : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers requests, expected
// responses are queued at each handshake and compared when the response arrives.
module tb_mem_port_arbiter;

  localparam int unsigned StarveLimit = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_req_valid, i_req_ready, i_flush, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return (a * 32'h9e37_79b9) ^ 32'h5a5a_0f0f;
  endfunction

  typedef struct {
    logic        is_i;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic        kill;
  } txn_t;

  txn_t sb[$];
  logic grant_log[$];
  int   cyc = 0;
  int   last_rsp_cyc = -100;
  int   i_rsp_cnt = 0;
  int   d_rsp_cnt = 0;

  int          ready_block = 0;
  int          rsp_delay = 0;
  logic        rsp_pending = 1'b0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: drives after the edge, observes acceptance mid-cycle.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'd0;
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_fn(rsp_addr);
          rsp_pending   = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      mem_req_ready = (ready_block == 0);
      if (ready_block > 0 && mem_req_valid) ready_block--;
      @(negedge clk);
      if (!rstn) rsp_pending = 1'b0;
      else if (mem_req_valid && mem_req_ready) begin
        rsp_pending = 1'b1;
        rsp_cnt     = rsp_delay;
        rsp_addr    = mem_req_addr;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;
    logic [3:0]  prev_wstrb;
    txn_t        t;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (i_flush && sb.size() > 0 && sb[0].is_i) sb[0].kill = 1'b1;
        check("dual_ready", 32'(i_req_ready & d_req_ready), 32'd0);
        if (sb.size() > 0) check("ready_busy", 32'(i_req_ready | d_req_ready), 32'd0);
        check("dual_rsp", 32'(i_rsp_valid & d_rsp_valid), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(mem_req_valid), 32'd1);
          check("stall_addr", mem_req_addr, prev_addr);
          check("stall_we", 32'(mem_req_we), 32'(prev_we));
          check("stall_wdata", mem_req_wdata, prev_wdata);
          check("stall_wstrb", 32'(mem_req_wstrb), 32'(prev_wstrb));
        end
        if (mem_req_valid) begin
          check("req_owned", 32'(sb.size()), 32'd1);
          if (mem_req_ready && sb.size() > 0) begin
            check("req_addr", mem_req_addr, sb[0].addr);
            check("req_we", 32'(mem_req_we), 32'(sb[0].we));
            check("req_wstrb", 32'(mem_req_wstrb), 32'(sb[0].wstrb));
            if (sb[0].we) check("req_wdata", mem_req_wdata, sb[0].wdata);
          end
        end
        if (mem_rsp_valid && sb.size() > 0) begin
          t = sb.pop_front();
          last_rsp_cyc = cyc;
          if (t.is_i) begin
            check("i_rsp_valid", 32'(i_rsp_valid), 32'(!t.kill));
            check("i_rsp_other", 32'(d_rsp_valid), 32'd0);
            if (!t.kill) check("i_rsp_data", i_rsp_data, t.data);
          end else begin
            check("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
            check("d_rsp_other", 32'(i_rsp_valid), 32'd0);
            if (!t.we) check("d_rsp_data", d_rsp_data, t.data);
          end
        end else begin
          check("rsp_unsolicited", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
        end
        if (i_rsp_valid) i_rsp_cnt++;
        if (d_rsp_valid) d_rsp_cnt++;
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        prev_we    = mem_req_we;
        prev_wdata = mem_req_wdata;
        prev_wstrb = mem_req_wstrb;
        if (i_req_valid && i_req_ready) begin
          sb.push_back('{is_i: 1'b1, addr: i_req_addr, we: 1'b0, wdata: 32'd0, wstrb: 4'd0,
                         data: mem_fn(i_req_addr), kill: 1'b0});
          grant_log.push_back(1'b1);
        end
        if (d_req_valid && d_req_ready) begin
          sb.push_back('{is_i: 1'b0, addr: d_req_addr, we: d_req_we, wdata: d_req_wdata,
                         wstrb: d_req_we ? d_req_wstrb : 4'd0, data: mem_fn(d_req_addr),
                         kill: 1'b0});
          grant_log.push_back(1'b0);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    check("idle_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_i_hs(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = i_req_valid && i_req_ready;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a);
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    wait_i_hs("fetch_hs");
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_i_ready"}, 32'(i_req_ready), 32'd0);
    check({tag, "_d_ready"}, 32'(d_req_ready), 32'd0);
    check({tag, "_mem_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_i_rsp"}, 32'(i_rsp_valid), 32'd0);
    check({tag, "_d_rsp"}, 32'(d_rsp_valid), 32'd0);
    check({tag, "_addr"}, mem_req_addr, 32'd0);
    check({tag, "_wdata"}, mem_req_wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(mem_req_wstrb), 32'd0);
    check({tag, "_i_data"}, i_rsp_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int hs_cyc;
    logic exp_g;
    i_req_valid = 1'b0; i_req_addr = 32'd0; i_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = 32'd0; d_req_we = 1'b0;
    d_req_wdata = 32'd0; d_req_wstrb = 4'd0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;  // requests during reset must not be accepted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Contention: both ports requesting continuously
    grant_log.delete();
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h1000;
    d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_we = 1'b0;
    d_req_wdata = 32'hcafe_f00d; d_req_wstrb = 4'hf;
    for (int k = 0; k < 200 && grant_log.size() < 10; k++) @(negedge clk);
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    check("contention_count", 32'(grant_log.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = ((k % 2) == 0);
`else
      exp_g = ((k % (StarveLimit + 1)) == StarveLimit);
`endif
      check($sformatf("grant%0d", k), 32'(grant_log[k]), 32'(exp_g));
    end
    wait_idle();

    // Lone fetch with zero-wait memory
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    @(negedge clk);
    check("lone_i_ready", 32'(i_req_ready), 32'd1);
    check("lone_d_ready", 32'(d_req_ready), 32'd0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("lone_mem_valid", 32'(mem_req_valid), 32'd1);
    check("lone_mem_addr", mem_req_addr, 32'h100);
    check("lone_mem_wstrb", 32'(mem_req_wstrb), 32'd0);
    @(negedge clk);
    check("lone_i_rsp", 32'(i_rsp_valid), 32'd1);
    check("lone_i_data", i_rsp_data, 32'h0000_0013);
    check("lone_d_rsp", 32'(d_rsp_valid), 32'd0);
    wait_idle();

    // Store held off by the memory for 5 cycles
    ready_block = 5;
    cnt0 = d_rsp_cnt;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40;
    d_req_wdata = 32'hdead_beef; d_req_wstrb = 4'b0011;
    @(negedge clk);
    check("st_d_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("st_valid%0d", k), 32'(mem_req_valid), 32'd1);
      check($sformatf("st_addr%0d", k), mem_req_addr, 32'h40);
      check($sformatf("st_we%0d", k), 32'(mem_req_we), 32'd1);
      check($sformatf("st_wdata%0d", k), mem_req_wdata, 32'hdead_beef);
      check($sformatf("st_wstrb%0d", k), 32'(mem_req_wstrb), 32'b0011);
    end
    wait_idle();
    check("st_rsp_count", 32'(d_rsp_cnt - cnt0), 32'd1);

    // Flush while the fetch waits for a delayed response
    rsp_delay = 3;
    cnt0 = i_rsp_cnt;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    @(negedge clk);
    check("fl_i_ready", 32'(i_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; rsp_delay = 0;
    i_req_valid = 1'b1; i_req_addr = 32'h300;
    wait_i_hs("fl_next_hs");
    hs_cyc = cyc;
    check("fl_next_cycle", 32'(hs_cyc - last_rsp_cyc), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_idle();
    check("fl_rsp_count", 32'(i_rsp_cnt - cnt0), 32'd1);

    // Flush landing in the same cycle as the response
    rsp_delay = 1;
    cnt0 = i_rsp_cnt;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    wait_i_hs("sim_hs");
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(negedge clk);
    check("sim_mem_rsp", 32'(mem_rsp_valid), 32'd1);
    check("sim_i_rsp", 32'(i_rsp_valid), 32'd0);
    @(posedge clk); #1;
    i_flush = 1'b0; rsp_delay = 0;
    wait_idle();
    check("sim_rsp_count", 32'(i_rsp_cnt - cnt0), 32'd0);

    // Reset while a request is stuck in ISSUE
    ready_block = 10;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h600;
    wait_i_hs("rst_hs");
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("rst_hold");
    @(posedge clk); #1;
    rstn = 1'b1; ready_block = 0;
    @(negedge clk);
    check("rst_idle_valid", 32'(mem_req_valid), 32'd0);
    cnt0 = i_rsp_cnt;
    fetch(32'h700);
    check("rst_fresh_rsp", 32'(i_rsp_cnt - cnt0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported instruction/data memory between the fetch stage's instruction port and the memory stage's load/store port. Each requester sees its own valid/ready request channel and its own response channel. The block issues exactly one memory transaction at a time and routes the response back to the requester that owns it. Fetch redirects can kill an in-flight fetch so that a stale instruction is never delivered.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the instruction port is forced to win (1..15)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req_valid  in  1  fetch read request
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  32  fetch address
- i_flush  in  1  fetch redirect; kill any in-flight fetch
- i_rsp_valid  out  1  fetch data valid (single-cycle pulse)
- i_rsp_data  out  32  fetch instruction word
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store accepted this cycle
- d_req_addr  in  32  load/store address
- d_req_we  in  1  1 = store
- d_req_wdata  in  32  store data
- d_req_wstrb  in  4  store byte enables
- d_rsp_valid  out  1  load data / store ack (single-cycle pulse)
- d_rsp_data  out  32  load data (don't-care for stores)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepted request
- mem_req_addr  out  32  memory address
- mem_req_we  out  1  memory write enable
- mem_req_wdata  out  32  memory write data
- mem_req_wstrb  out  4  memory byte enables (4'b0000 for reads)
- mem_rsp_valid  in  1  memory response (exactly one per accepted request, reads and writes)
- mem_rsp_data  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - Compute grant from the valid requesters. Assert req_ready combinationally for the winner only.
  - On handshake, register addr/we/wdata/wstrb and owner (I or D), clear the kill flag, and go to ISSUE.
  - Instruction requests register we=0 and wstrb=0.
- **ISSUE:**
  - mem_req_valid=1, driven from the registered fields.
  - Fields are held stable until mem_req_ready. Valid is never retracted.
  - On mem_req_ready, go to WAIT.
- **WAIT:**
  - On mem_rsp_valid, pulse the owner's rsp_valid in the same cycle, with rsp_data = mem_rsp_data passed through combinationally. Then go to IDLE.
  - If the kill flag is set, the owner is I, and mem_rsp_valid arrives: consume the response, keep i_rsp_valid=0, and go to IDLE.
- **Kill flag:**
  - Set when i_flush=1 while owner=I in ISSUE or WAIT.
  - i_flush with owner=D has no effect.
  - i_flush in IDLE has no effect. The fetch request presented in the same cycle is still arbitrated normally.
- **Default arbitration** is fixed priority, D over I.
- **Starvation counter** (4-bit, saturating):
  - Increments on every grant to D while i_req_valid=1.
  - Clears on any grant to I.
  - When the counter is at or above STARVE_LIMIT and i_req_valid=1, I wins.
- mem_rsp_valid in IDLE or ISSUE is ignored and no rsp_valid is produced.
- Both rsp_valid outputs are never high in the same cycle. At most one transaction is outstanding.

## Timing
- **Reset values:**
  - State=IDLE, kill=0, starve counter=0, owner=D.
  - mem_req_valid, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid = 0 while rstn=0.
  - mem_req_addr, wdata and wstrb registers = 0. Data outputs = 0 while in reset.
- **Latency:**
  - Request handshake in cycle N.
  - mem_req_valid first high in N+1.
  - With zero-wait memory (ready in N+1, rsp in N+2), rsp_valid in N+2.
  - Next grant in N+3. Peak throughput is one transaction per 3 cycles.
- req_ready is high only in IDLE, and only for the granted valid requester.
- Reset mid-transaction returns to IDLE next edge and drops mem_req_valid. The memory subsystem is reset together with this block.
- Simultaneous i_flush and mem_rsp_valid in WAIT (owner I): response suppressed, i_rsp_valid=0.

## Configuration
- **MEM_ARB_ROUND_ROBIN_EN defined:**
  - Fixed priority is replaced by two-way round-robin, using a 1-bit last-grant register (reset value = D, so I wins the first tie).
  - When both requests are valid, the winner is the port not granted last.
  - The starvation counter and STARVE_LIMIT are unused and stay at 0.
- **Not defined:** fixed D-over-I priority with the starvation counter, as described above.

## Test plan
- **Lone fetch:** i_req_valid=1, addr=0x100; memory ready immediately, rsp next cycle with 0x00000013 -> i_req_ready in cycle 0, mem_req_valid in cycle 1 with addr 0x100 and wstrb=0, i_rsp_valid with data 0x00000013 in cycle 2, d_rsp_valid stays 0.
- **Contention (macro off):**
  - Stimulus: i_req_valid and d_req_valid held high continuously; STARVE_LIMIT=4.
  - Required grant order: D, D, D, D, I, D, D, D, D, I…
  - Verify that each i_rsp_valid carries the memory data for the fetch address.
- **Contention (macro on):** same stimulus -> grants alternate I, D, I, D starting with I.
- **Flush in WAIT:**
  - Fetch to 0x200 accepted; mem_req_ready asserted; i_flush pulsed 1 cycle while the memory holds off the response for 3 cycles.
  - Required: i_rsp_valid never asserts for that fetch.
  - A new fetch to 0x300 is accepted in the cycle after the response, and its data is delivered.
- **Store with backpressure:**
  - Stimulus: d_req_we=1, addr=0x40, wdata=0xDEADBEEF, wstrb=4'b0011; mem_req_ready low for 5 cycles.
  - Required: mem_req_valid and all fields stay stable for 6 cycles; d_rsp_valid pulses once on mem_rsp_valid.
- **Reset mid-ISSUE:** rstn=0 while mem_req_valid=1 -> next edge mem_req_valid=0, all ready/rsp outputs 0, state IDLE; after release a fresh fetch completes normally.
